// File: rtl/parking_meter_counter.sv
// rtl/parking_meter_counter.sv - parking meter time-remaining counter; optional BLINK phase under `METER_BLINK_EN
module parking_meter_counter #(
    parameter int WIDTH      = 16,
    parameter int MAX_COUNT  = 9999,
    parameter int TICK_DIV   = 100000000,
    parameter int INC_UP     = 10,
    parameter int INC_LEFT   = 180,
    parameter int INC_RIGHT  = 200,
    parameter int INC_DOWN   = 550,
    parameter int PRESET0    = 10,
    parameter int PRESET1    = 205,
    parameter int WARN_LIMIT = 200
) (
    input  logic             SYS_CLK,
    input  logic             RESET,
    input  logic             UP,
    input  logic             LEFT,
    input  logic             RIGHT,
    input  logic             DOWN,
    input  logic             SW0,
    input  logic             SW1,
    output logic [WIDTH-1:0] COUNT,
    output logic             EXPIRED,
    output logic             LOW_WARN,
    output logic             TICK,
    output logic             BLINK
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [WIDTH:0]   MAX_EXT    = (WIDTH+1)'(MAX_COUNT);
    localparam logic [WIDTH-1:0] MAX_W      = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH:0]   INC_UP_E   = (WIDTH+1)'(INC_UP);
    localparam logic [WIDTH:0]   INC_LEFT_E = (WIDTH+1)'(INC_LEFT);
    localparam logic [WIDTH:0]   INC_RGT_E  = (WIDTH+1)'(INC_RIGHT);
    localparam logic [WIDTH:0]   INC_DOWN_E = (WIDTH+1)'(INC_DOWN);
    localparam logic [WIDTH-1:0] PRESET0_W  = WIDTH'(PRESET0);
    localparam logic [WIDTH-1:0] PRESET1_W  = WIDTH'(PRESET1);
    localparam logic [WIDTH-1:0] WARN_W     = WIDTH'(WARN_LIMIT);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Button bit order: [0]=UP, [1]=LEFT, [2]=RIGHT, [3]=DOWN (also the priority order)
    logic [3:0]       btn_meta_q, btn_meta_d;
    logic [3:0]       btn_sync_q, btn_sync_d;
    logic [3:0]       btn_prev_q, btn_prev_d;
    logic [3:0]       btn_edge_q, btn_edge_d;
    // Switch bit order: [0]=SW0, [1]=SW1
    logic [1:0]       sw_meta_q, sw_meta_d;
    logic [1:0]       sw_sync_q, sw_sync_d;

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             expired_q, expired_d;
    logic             low_warn_q, low_warn_d;
    logic [WIDTH:0]   inc_sel;
    logic [WIDTH:0]   sum_ext;

    // Input conditioning: two-flop synchronisers, then a registered rising-edge pulse per button
    always_comb begin
        btn_meta_d = {DOWN, RIGHT, LEFT, UP};
        btn_sync_d = btn_meta_q;
        btn_prev_d = btn_sync_q;
        btn_edge_d = btn_sync_q & ~btn_prev_q;
        sw_meta_d  = {SW1, SW0};
        sw_sync_d  = sw_meta_q;
    end

    // One action per cycle: switch preset > HOLD exit > button add > tick decrement
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        div_d   = tick_q ? '0 : div_q + 1'b1;
        inc_sel = '0;
        sum_ext = '0;
        if (sw_sync_q[0]) begin
            count_d = PRESET0_W;
            state_d = ST_HOLD;
        end else if (sw_sync_q[1]) begin
            count_d = PRESET1_W;
            state_d = ST_HOLD;
        end else if (state_q == ST_HOLD) begin
            // Leaving HOLD restarts the divider so the first decrement is a full period away
            state_d = (count_q != '0) ? ST_RUN : ST_EMPTY;
            div_d   = '0;
        end else if (btn_edge_q != '0) begin
            if (btn_edge_q[0]) begin
                inc_sel = INC_UP_E;
            end else if (btn_edge_q[1]) begin
                inc_sel = INC_LEFT_E;
            end else if (btn_edge_q[2]) begin
                inc_sel = INC_RGT_E;
            end else begin
                inc_sel = INC_DOWN_E;
            end
            sum_ext = {1'b0, count_q} + inc_sel;
            count_d = (sum_ext > MAX_EXT) ? MAX_W : sum_ext[WIDTH-1:0];
            state_d = (count_d != '0) ? ST_RUN : ST_EMPTY;
        end else if (tick_q && (state_q == ST_RUN) && (count_q != '0)) begin
            count_d = count_q - 1'b1;
            state_d = (count_d == '0) ? ST_EMPTY : ST_RUN;
        end
    end

    // Status flags and tick pulse follow the next-state values so they move with COUNT
    always_comb begin
        tick_d     = (div_d == DIV_LAST);
        expired_d  = (count_d == '0);
        low_warn_d = (count_d != '0) && (count_d < WARN_W);
    end

`ifdef METER_BLINK_EN
    logic blink_q, blink_d;

    // Blink phase flips on each tick while the meter is low or expired, and rests at 0 otherwise
    always_comb begin
        blink_d = blink_q;
        if ((state_q == ST_HOLD) || (state_d == ST_HOLD) || !(expired_d || low_warn_d)) begin
            blink_d = 1'b0;
        end else if (tick_q) begin
            blink_d = ~blink_q;
        end
    end

    // Blink phase register
    always_ff @(posedge SYS_CLK or negedge RESET) begin
        if (!RESET) begin
            blink_q <= 1'b0;
        end else begin
            blink_q <= blink_d;
        end
    end

    assign BLINK = blink_q;
`else
    assign BLINK = 1'b0;
`endif

    // State, counter, divider and conditioning registers
    always_ff @(posedge SYS_CLK or negedge RESET) begin
        if (!RESET) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            btn_prev_q <= '0;
            btn_edge_q <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            div_q      <= '0;
            tick_q     <= 1'b0;
            state_q    <= ST_EMPTY;
            count_q    <= '0;
            expired_q  <= 1'b1;
            low_warn_q <= 1'b0;
        end else begin
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
            btn_prev_q <= btn_prev_d;
            btn_edge_q <= btn_edge_d;
            sw_meta_q  <= sw_meta_d;
            sw_sync_q  <= sw_sync_d;
            div_q      <= div_d;
            tick_q     <= tick_d;
            state_q    <= state_d;
            count_q    <= count_d;
            expired_q  <= expired_d;
            low_warn_q <= low_warn_d;
        end
    end

    assign COUNT    = count_q;
    assign EXPIRED  = expired_q;
    assign LOW_WARN = low_warn_q;
    assign TICK     = tick_q;

endmodule

// File: tb/tb_parking_meter_counter.sv
// tb/tb_parking_meter_counter.sv - self-checking bench for parking_meter_counter
module tb_parking_meter_counter;

    localparam int W      = 16;
    localparam int MAXC   = 9999;
    localparam int TD     = 4;
    localparam int I_UP   = 10;
    localparam int I_LEFT = 180;
    localparam int I_RGT  = 200;
    localparam int I_DOWN = 550;
    localparam int P0     = 10;
    localparam int P1     = 205;
    localparam int WARN   = 200;

    logic         SYS_CLK = 1'b0;
    logic         RESET   = 1'b0;
    logic         UP = 1'b0, LEFT = 1'b0, RIGHT = 1'b0, DOWN = 1'b0;
    logic         SW0 = 1'b0, SW1 = 1'b0;
    logic [W-1:0] COUNT;
    logic         EXPIRED, LOW_WARN, TICK, BLINK;

    int errors = 0;
    int checks = 0;
    int nidx   = 0;

    parking_meter_counter #(
        .WIDTH(W), .MAX_COUNT(MAXC), .TICK_DIV(TD),
        .INC_UP(I_UP), .INC_LEFT(I_LEFT), .INC_RIGHT(I_RGT), .INC_DOWN(I_DOWN),
        .PRESET0(P0), .PRESET1(P1), .WARN_LIMIT(WARN)
    ) dut (
        .SYS_CLK(SYS_CLK), .RESET(RESET),
        .UP(UP), .LEFT(LEFT), .RIGHT(RIGHT), .DOWN(DOWN),
        .SW0(SW0), .SW1(SW1),
        .COUNT(COUNT), .EXPIRED(EXPIRED), .LOW_WARN(LOW_WARN),
        .TICK(TICK), .BLINK(BLINK)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic goto(input int t);
        while (nidx < t) begin
            @(negedge SYS_CLK);
            nidx++;
        end
    endtask

    // Behavioural model: pin histories give the input latency, then the meter rules apply
    int         m_count;
    bit         m_hold;
    int         m_phase;
    bit         m_blink;
    logic [3:0] bh [0:4];
    logic [1:0] sh [0:2];

    always @(posedge SYS_CLK or negedge RESET) begin : model
        bit         tick, was_hold;
        logic [3:0] ev;
        int         inc;
        if (!RESET) begin
            m_count = 0;
            m_hold  = 0;
            m_phase = 0;
            m_blink = 0;
            for (int i = 0; i < 5; i++) bh[i] = '0;
            for (int i = 0; i < 3; i++) sh[i] = '0;
        end else begin
            for (int i = 4; i > 0; i--) bh[i] = bh[i-1];
            bh[0] = {DOWN, RIGHT, LEFT, UP};
            for (int i = 2; i > 0; i--) sh[i] = sh[i-1];
            sh[0] = {SW1, SW0};
            ev       = bh[3] & ~bh[4];
            tick     = (m_phase == TD - 1);
            was_hold = m_hold;
            m_phase  = tick ? 0 : m_phase + 1;
            if (sh[2][0]) begin
                m_count = P0;
                m_hold  = 1;
            end else if (sh[2][1]) begin
                m_count = P1;
                m_hold  = 1;
            end else if (m_hold) begin
                m_hold  = 0;
                m_phase = 0;
            end else if (ev != 4'b0) begin
                inc = ev[0] ? I_UP : ev[1] ? I_LEFT : ev[2] ? I_RGT : I_DOWN;
                m_count = (m_count + inc > MAXC) ? MAXC : m_count + inc;
            end else if (tick && m_count > 0) begin
                m_count = m_count - 1;
            end
`ifdef METER_BLINK_EN
            if (was_hold || m_hold || m_count >= WARN) m_blink = 0;
            else if (tick) m_blink = !m_blink;
`else
            m_blink = 0;
`endif
        end
    end

    // Every-cycle comparison against the model
    always @(negedge SYS_CLK) begin
        if (RESET) begin
            chk("model_count", COUNT, m_count);
            chk("model_expired", EXPIRED, (m_count == 0));
            chk("model_low_warn", LOW_WARN, (m_count > 0 && m_count < WARN));
            chk("model_tick", TICK, (m_phase == TD - 1));
            chk("model_blink", BLINK, m_blink);
        end
    end

    initial begin
        repeat (3) @(negedge SYS_CLK);
        chk("rst_count", COUNT, 0);
        chk("rst_expired", EXPIRED, 1);
        chk("rst_low_warn", LOW_WARN, 0);
        chk("rst_tick", TICK, 0);
        chk("rst_blink", BLINK, 0);

        // Three UP presses, then UP held for 50 cycles
        RESET = 1'b1; UP = 1'b1; nidx = 0;
        goto(1);  UP = 1'b0;
        goto(2);  chk("tick_low", TICK, 0); UP = 1'b1;
        goto(3);  chk("tick_high", TICK, 1); chk("up_latency", COUNT, 0);
                  chk("expired_before_add", EXPIRED, 1); UP = 1'b0;
        goto(4);  chk("up_first", COUNT, 10); UP = 1'b1;
        goto(5);  UP = 1'b0;
        goto(8);  chk("up_three", COUNT, 30); chk("expired_cleared", EXPIRED, 0);
                  chk("low_warn_30", LOW_WARN, 1); UP = 1'b1;
        goto(58); chk("up_held", COUNT, 29); UP = 1'b0;

        // DOWN press train up to and past the ceiling
        for (int i = 0; i < 20; i++) begin
            goto(60 + 2*i); DOWN = 1'b1;
            goto(61 + 2*i); DOWN = 1'b0;
        end
        goto(100); chk("sat_reach", COUNT, 9999);
        goto(102); chk("sat_press_at_max", COUNT, 9999);
        goto(104); chk("sat_then_tick", COUNT, 9998); SW0 = 1'b1;

        // SW0 preset, then countdown to zero
        goto(110); chk("sw0_preset", COUNT, 10);
        goto(120); SW0 = 1'b0;
        goto(158); chk("cd_two", COUNT, 2);
        goto(159); chk("cd_one", COUNT, 1);
        goto(162); chk("cd_one_hold", COUNT, 1);
        goto(163); chk("cd_zero", COUNT, 0); chk("cd_expired", EXPIRED, 1);
        goto(171); chk("cd_floor", COUNT, 0);

        // SW1 hold with LEFT pulses ignored, then exit and decrement timing
        goto(172); SW1 = 1'b1;
        goto(176); chk("sw1_preset", COUNT, 205);
        for (int i = 0; i < 8; i++) begin
            goto(176 + 2*i); LEFT = 1'b1;
            goto(177 + 2*i); LEFT = 1'b0;
        end
        goto(192); chk("sw1_ignores_left", COUNT, 205); SW1 = 1'b0;
        goto(194); chk("sw1_tail", COUNT, 205);
        goto(198); chk("exit_no_dec_yet", COUNT, 205);
        goto(199); chk("exit_first_dec", COUNT, 204); chk("lw_204", LOW_WARN, 0);
        goto(218); chk("cnt_200", COUNT, 200); chk("lw_200", LOW_WARN, 0);
        goto(219); chk("cnt_199", COUNT, 199); chk("lw_199", LOW_WARN, 1);

        // Fresh start: simultaneous UP and RIGHT, then both switches
        goto(220); #1 RESET = 1'b0;
        goto(222); RESET = 1'b1; UP = 1'b1; RIGHT = 1'b1; nidx = 0;
        goto(1);  UP = 1'b0; RIGHT = 1'b0;
        goto(4);  chk("up_beats_right", COUNT, 10);
        goto(5);  SW0 = 1'b1; SW1 = 1'b1;
        goto(10); chk("sw0_beats_sw1", COUNT, 10);
        goto(12); SW0 = 1'b0; SW1 = 1'b0;
        goto(56); chk("drain_zero", COUNT, 0); chk("drain_expired", EXPIRED, 1); LEFT = 1'b1;
        goto(57); LEFT = 1'b0;
        goto(60); chk("left_add", COUNT, 180); chk("left_not_expired", EXPIRED, 0);

        // Asynchronous reset mid-period at COUNT=150
        goto(181); chk("pre_reset_150", COUNT, 150); chk("pre_reset_lw", LOW_WARN, 1);
        #2 RESET = 1'b0;
        #1;
        chk("async_count", COUNT, 0);
        chk("async_expired", EXPIRED, 1);
        chk("async_low_warn", LOW_WARN, 0);
        chk("async_tick", TICK, 0);
        chk("async_blink", BLINK, 0);
        repeat (2) @(negedge SYS_CLK);
        RESET = 1'b1;
        repeat (6) @(negedge SYS_CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
